// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues data-memory requests,
// formats store lanes and load results, and emits one writeback record per instruction.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [4:0]        ex_rd,
    input  logic              ex_load_regfile,
    input  logic [ADDR_W-1:0] ex_pc,
    output logic              mem_stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_load_regfile,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_pc,
    output logic              mem_fault
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [4:0]        rd;
        logic              lrf;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
        logic              fault;
    } wb_rec_t;

    state_t state, state_next;

    logic accept, issue, complete;
    logic is_mem, bad_funct, misaligned, fault;
    logic [1:0] off;
    logic [3:0] be_raw, be_c;
    logic [DATA_W-1:0] wdata_c;

    // Outstanding access context, needed to format the load result at response time
    logic              p_load;
    logic [2:0]        p_funct3;
    logic [1:0]        p_off;
    logic [4:0]        p_rd;
    logic              p_lrf;
    logic [ADDR_W-1:0] p_pc;
    logic [DATA_W-1:0] p_result;

    logic [DATA_W-1:0] ld_shift, load_data;

    wb_rec_t acc_rec, comp_rec, out_rec, hold_rec, q_rec;
    logic    acc_v, comp_v, out_v, hold_v, q_v;

    assign off = ex_addr[1:0];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = ACCESS;
            ACCESS:  if (dmem_resp) state_next = issue ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output / handshake logic ----------------
    always_comb begin
        mem_stall = (state == ACCESS) && !dmem_resp;
        accept    = ex_valid && !mem_stall;
        complete  = (state == ACCESS) && dmem_resp;
        issue     = accept && is_mem && !fault;
    end

    // Legality and alignment of the presented memory op
    always_comb begin
        is_mem    = ex_load || ex_store;
        bad_funct = 1'b0;
        if (ex_load)
            bad_funct = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
        if (ex_store)
            bad_funct = bad_funct || ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
        misaligned = ((ex_funct3[1:0] == 2'b01) && off[0])
                  || ((ex_funct3[1:0] == 2'b10) && (off != 2'b00));
        fault = is_mem && ((ex_load && ex_store) || bad_funct || misaligned);
    end

    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                be_raw  = 4'b0001;
                wdata_c = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_raw  = 4'b0011;
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: begin
                be_raw  = 4'b1111;
                wdata_c = ex_store_data;
            end
        endcase
        be_c = be_raw << off;
    end

    always_comb begin
        ld_shift = dmem_rdata >> {p_off, 3'b000};
        case (p_funct3)
            3'b000:  load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  load_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  load_data = {24'b0, ld_shift[7:0]};
            3'b101:  load_data = {16'b0, ld_shift[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Records produced this cycle: completing access (older) and an accepted
    // non-issuing instruction (younger).
    always_comb begin
        acc_v         = accept && !issue;
        acc_rec       = '0;
        acc_rec.rd    = ex_rd;
        acc_rec.pc    = ex_pc;
        acc_rec.fault = fault;
        acc_rec.lrf   = !fault && ex_load_regfile && (ex_rd != 5'd0);
        acc_rec.data  = fault ? '0 : ex_result;

        comp_v         = complete;
        comp_rec       = '0;
        comp_rec.rd    = p_rd;
        comp_rec.pc    = p_pc;
        comp_rec.lrf   = p_load && p_lrf;
        comp_rec.data  = p_load ? load_data : p_result;
    end

    // When an access completes in the same cycle a non-memory op is accepted,
    // both records arrive together; the younger one waits in q one cycle and
    // subsequent single-cycle ops ride behind it until a bubble drains it.
    always_comb begin
        out_v    = 1'b0;
        out_rec  = '0;
        hold_v   = 1'b0;
        hold_rec = '0;
        if (q_v) begin
            out_v    = 1'b1;
            out_rec  = q_rec;
            hold_v   = comp_v || acc_v;
            hold_rec = comp_v ? comp_rec : acc_rec;
        end else if (comp_v) begin
            out_v    = 1'b1;
            out_rec  = comp_rec;
            hold_v   = acc_v;
            hold_rec = acc_rec;
        end else if (acc_v) begin
            out_v    = 1'b1;
            out_rec  = acc_rec;
        end
    end

    // ---------------- registered datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= '0;
            p_load           <= 1'b0;
            p_funct3         <= '0;
            p_off            <= '0;
            p_rd             <= '0;
            p_lrf            <= 1'b0;
            p_pc             <= '0;
            p_result         <= '0;
            q_v              <= 1'b0;
            q_rec            <= '0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_load_regfile  <= 1'b0;
            wb_data          <= '0;
            wb_pc            <= '0;
            mem_fault        <= 1'b0;
        end else begin
            if (issue) begin
                dmem_read        <= ex_load;
                dmem_write       <= ex_store;
                dmem_address     <= {ex_addr[ADDR_W-1:2], 2'b00};
                dmem_wdata       <= wdata_c;
                dmem_byte_enable <= be_c;
                p_load           <= ex_load;
                p_funct3         <= ex_funct3;
                p_off            <= off;
                p_rd             <= ex_rd;
                p_lrf            <= ex_load_regfile && (ex_rd != 5'd0);
                p_pc             <= ex_pc;
                p_result         <= ex_result;
            end else if (complete) begin
                dmem_read  <= 1'b0;
                dmem_write <= 1'b0;
            end

            q_v   <= hold_v;
            q_rec <= hold_rec;

            wb_valid        <= out_v;
            wb_rd           <= out_rec.rd;
            wb_load_regfile <= out_v && out_rec.lrf;
            wb_data         <= out_rec.data;
            wb_pc           <= out_rec.pc;
            mem_fault       <= out_v && out_rec.fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized single ops
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_load, ex_store, ex_load_regfile;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data, ex_result, ex_pc;
    logic [4:0]  ex_rd;
    logic        mem_stall, dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;
    logic        wb_valid, wb_load_regfile, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_result(ex_result), .ex_rd(ex_rd), .ex_load_regfile(ex_load_regfile),
        .ex_pc(ex_pc), .mem_stall(mem_stall), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
        .wb_data(wb_data), .wb_pc(wb_pc), .mem_fault(mem_fault)
    );

    // ---------------- reference model ----------------
    function automatic logic ref_fault(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] a);
        int unsigned sz = 32'(f3) % 4;
        if (ld && st) return 1'b1;
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (st && f3 >= 3) return 1'b1;
        if ((ld || st) && sz == 1 && (a % 2) != 0) return 1'b1;
        if ((ld || st) && sz == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned nbytes = 32'd1 << (32'(f3) % 4);
        int unsigned mask = (32'd1 << nbytes) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (32'(f3) % 4)
            0:       return (d % 256) * 32'h0101_0101;
            1:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        int unsigned w = rdata / (32'd1 << (8 * (a % 4)));
        int unsigned b = w % 256;
        int unsigned h = w % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_ex(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] res,
                            input logic [4:0] rd, input logic lrf, input logic [31:0] pc);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = a;
        ex_store_data = sd; ex_result = res; ex_rd = rd; ex_load_regfile = lrf; ex_pc = pc;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_stall, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
             wb_valid, wb_rd, wb_load_regfile, wb_data, wb_pc, mem_fault} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got stall=%b rd=%b wr=%b addr=%h wbv=%b flt=%b, required all 0",
                     mem_stall, dmem_read, dmem_write, dmem_address, wb_valid, mem_fault);
        end
        rst = 1'b0;
    endtask

    // One instruction in isolation with a chosen response latency (cycles from request to resp).
    task automatic test_single_op(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd, input logic [31:0] res,
                                  input logic [4:0] rd, input logic lrf, input logic [31:0] pc,
                                  input int unsigned lat, input logic [31:0] rdata);
        logic        flt, mem_ok, exp_lrf;
        logic [31:0] exp_data;
        flt     = ref_fault(ld, st, f3, a);
        mem_ok  = (ld || st) && !flt;
        exp_lrf = !flt && !st && lrf && (rd != 0);
        exp_data = flt ? 32'd0 : (ld ? ref_load(f3, a, rdata) : res);

        @(negedge clk);
        vectors++;
        if (wb_valid !== 1'b0 || mem_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL wb_one_cycle: got wb_valid=%b mem_fault=%b, required 0 0", wb_valid, mem_fault);
        end
        drive_ex(ld, st, f3, a, sd, res, rd, lrf, pc);
        @(negedge clk);
        clear_ex();

        if (mem_ok) begin
            vectors++;
            if (dmem_read !== ld || dmem_write !== st || dmem_address !== (a & 32'hFFFF_FFFC) ||
                dmem_byte_enable !== ref_be(f3, a) || (st && dmem_wdata !== ref_wdata(f3, sd))) begin
                miscompares++;
                $display("FAIL request: got rd=%b wr=%b addr=%h be=%b wdata=%h, required rd=%b wr=%b addr=%h be=%b wdata=%h",
                         dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
                         ld, st, a & 32'hFFFF_FFFC, ref_be(f3, a), ref_wdata(f3, sd));
            end
            for (int unsigned c = 1; c <= lat; c++) begin
                vectors++;
                if (mem_stall !== 1'b1 || wb_valid !== 1'b0 || dmem_read !== ld || dmem_write !== st ||
                    dmem_address !== (a & 32'hFFFF_FFFC)) begin
                    miscompares++;
                    $display("FAIL access_hold: cycle %0d got stall=%b wbv=%b rd=%b wr=%b addr=%h, required stall=1 wbv=0 rd=%b wr=%b addr=%h",
                             c, mem_stall, wb_valid, dmem_read, dmem_write, dmem_address, ld, st, a & 32'hFFFF_FFFC);
                end
                if (c < lat) @(negedge clk);
            end
            dmem_resp = 1'b1;
            dmem_rdata = rdata;
            #1;
            vectors++;
            if (mem_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_on_resp: got %b, required 0", mem_stall);
            end
            @(negedge clk);
            dmem_resp = 1'b0;
            dmem_rdata = $urandom;
        end

        vectors++;
        if (wb_valid !== 1'b1 || wb_rd !== rd || wb_pc !== pc || mem_fault !== flt) begin
            miscompares++;
            $display("FAIL wb_record: got v=%b rd=%0d pc=%h flt=%b, required v=1 rd=%0d pc=%h flt=%b",
                     wb_valid, wb_rd, wb_pc, mem_fault, rd, pc, flt);
        end
        vectors++;
        if (wb_data !== exp_data) begin
            miscompares++;
            $display("FAIL wb_data: got %h, required %h (f3=%0d addr=%h)", wb_data, exp_data, f3, a);
        end
        vectors++;
        if (wb_load_regfile !== exp_lrf) begin
            miscompares++;
            $display("FAIL wb_load_regfile: got %b, required %b", wb_load_regfile, exp_lrf);
        end
        vectors++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL request_idle: got rd=%b wr=%b, required 0 0", dmem_read, dmem_write);
        end
    endtask

    task automatic test_reset_during_access();
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'd0, 5'd3, 1'b1, 32'h0000_1000);
        @(negedge clk);
        clear_ex();
        vectors++;
        if (dmem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_read: got %b, required 1", dmem_read);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abandon: got rd=%b wr=%b wbv=%b stall=%b, required 0 0 0 0",
                     dmem_read, dmem_write, wb_valid, mem_stall);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_resp = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            vectors++;
            if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL late_resp: cycle %0d got wbv=%b stall=%b, required 0 0", c, wb_valid, mem_stall);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        // sw 0x400 then lw 0x404 accepted in the response cycle
        @(negedge clk);
        drive_ex(1'b0, 1'b1, 3'd2, 32'h0000_0400, 32'hA5A5_0001, 32'd0, 5'd7, 1'b1, 32'h0000_2000);
        @(negedge clk);
        vectors++;
        if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_address !== 32'h400 ||
            dmem_wdata !== 32'hA5A5_0001 || dmem_byte_enable !== 4'b1111) begin
            miscompares++;
            $display("FAIL b2b_sw_req: got wr=%b rd=%b addr=%h wdata=%h be=%b", dmem_write, dmem_read,
                     dmem_address, dmem_wdata, dmem_byte_enable);
        end
        dmem_resp = 1'b1;
        drive_ex(1'b1, 1'b0, 3'd2, 32'h0000_0404, 32'd0, 32'd0, 5'd9, 1'b1, 32'h0000_2004);
        #1;
        vectors++;
        if (mem_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stall: got %b, required 0", mem_stall);
        end
        @(negedge clk);
        clear_ex();
        vectors++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h2000 || wb_load_regfile !== 1'b0 || mem_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_wb_sw: got v=%b pc=%h lrf=%b flt=%b, required 1 00002000 0 0",
                     wb_valid, wb_pc, wb_load_regfile, mem_fault);
        end
        vectors++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 32'h404) begin
            miscompares++;
            $display("FAIL b2b_lw_req: got rd=%b wr=%b addr=%h, required 1 0 00000404",
                     dmem_read, dmem_write, dmem_address);
        end
        dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_resp = 1'b0;
        vectors++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h2004 || wb_data !== 32'h1357_9BDF ||
            wb_rd !== 5'd9 || wb_load_regfile !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_wb_lw: got v=%b pc=%h data=%h rd=%0d lrf=%b, required 1 00002004 13579bdf 9 1",
                     wb_valid, wb_pc, wb_data, wb_rd, wb_load_regfile);
        end

        // sw completing while two ALU ops follow back-to-back: order must hold
        @(negedge clk);
        drive_ex(1'b0, 1'b1, 3'd0, 32'h0000_0411, 32'h0000_00C3, 32'd0, 5'd1, 1'b0, 32'h0000_3000);
        @(negedge clk);
        dmem_resp = 1'b1;
        drive_ex(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h1111_1111, 5'd4, 1'b1, 32'h0000_3004);
        @(negedge clk);
        dmem_resp = 1'b0;
        drive_ex(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h2222_2222, 5'd5, 1'b1, 32'h0000_3008);
        vectors++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h3000) begin
            miscompares++;
            $display("FAIL order_sw: got v=%b pc=%h, required 1 00003000", wb_valid, wb_pc);
        end
        @(negedge clk);
        clear_ex();
        vectors++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h3004 || wb_data !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL order_alu1: got v=%b pc=%h data=%h, required 1 00003004 11111111", wb_valid, wb_pc, wb_data);
        end
        @(negedge clk);
        vectors++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h3008 || wb_data !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL order_alu2: got v=%b pc=%h data=%h, required 1 00003008 22222222", wb_valid, wb_pc, wb_data);
        end
        @(negedge clk);
        vectors++;
        if (wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL order_drain: got wb_valid=%b, required 0", wb_valid);
        end
    endtask

    task automatic test_alu_stream();
        logic [31:0] res [3];
        for (int i = 0; i < 3; i++) res[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (wb_valid !== 1'b1 || wb_data !== res[i-1] || wb_pc !== 32'(32'h4000 + 4 * (i - 1)) ||
                    wb_rd !== 5'(10 + i - 1) || mem_stall !== 1'b0) begin
                    miscompares++;
                    $display("FAIL alu_stream: op %0d got v=%b data=%h pc=%h rd=%0d stall=%b, required 1 %h %h %0d 0",
                             i - 1, wb_valid, wb_data, wb_pc, wb_rd, mem_stall, res[i-1],
                             32'(32'h4000 + 4 * (i - 1)), 10 + i - 1);
                end
            end
            if (i < 3) drive_ex(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, res[i], 5'(10 + i), 1'b1, 32'(32'h4000 + 4 * i));
            else clear_ex();
        end
    endtask

    task automatic test_random_ops(input int unsigned n);
        int unsigned kind;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int unsigned i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            ld = (kind >= 1 && kind <= 4) || kind == 9;
            st = (kind >= 5 && kind <= 8) || kind == 9;
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            test_single_op(ld, st, f3, a, $urandom, $urandom, 5'($urandom_range(0, 31)),
                           1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 4), $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_ex();
        ex_funct3 = '0; ex_addr = '0; ex_store_data = '0; ex_result = '0;
        ex_rd = '0; ex_load_regfile = 1'b0; ex_pc = '0;
        dmem_resp = 1'b0; dmem_rdata = '0;

        test_reset();
        test_reset_during_access();
        // lb 0x103, 3-cycle response
        test_single_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'd0, 5'd6, 1'b1, 32'h0000_0040, 3, 32'h80FF_1234);
        // lhu 0x202 and sh 0x202
        test_single_op(1'b1, 1'b0, 3'd5, 32'h0000_0202, 32'd0, 32'd0, 5'd8, 1'b1, 32'h0000_0044, 1, 32'hBEEF_0000);
        test_single_op(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_5678, 32'd0, 5'd8, 1'b1, 32'h0000_0048, 2, 32'd0);
        // faults: misaligned lw and illegal load funct3
        test_single_op(1'b1, 1'b0, 3'd2, 32'h0000_0301, 32'd0, 32'h5555_5555, 5'd2, 1'b1, 32'h0000_004C, 1, 32'd0);
        test_single_op(1'b1, 1'b0, 3'd7, 32'h0000_0300, 32'd0, 32'h5555_5555, 5'd2, 1'b1, 32'h0000_0050, 1, 32'd0);
        // lw to x0
        test_single_op(1'b1, 1'b0, 3'd2, 32'h0000_0310, 32'd0, 32'd0, 5'd0, 1'b1, 32'h0000_0054, 2, 32'hCAFE_F00D);
        test_back_to_back();
        test_alu_stream();
        test_random_ops(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined RV32I core, between the execute stage and writeback.
- Issues data-memory read/write requests with a request/response handshake.
- Generates byte enables and store-data lane replication, and sign/zero-extends load data.
- Stalls upstream while an access is outstanding and delivers one writeback record per instruction.

Parameters:
- ADDR_W, 32, width of the data address and PC.
- DATA_W, 32, data word width (fixed at 32; byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store
- ex_funct3  in  3  load/store funct3 (lb=000 lh=001 lw=010 lbu=100 lhu=101; sb=000 sh=001 sw=010)
- ex_addr  in  32  effective address (ALU result)
- ex_store_data  in  32  rs2 value
- ex_result  in  32  non-memory result passed to writeback
- ex_rd  in  5  destination register
- ex_load_regfile  in  1  instruction writes rd
- ex_pc  in  32  instruction PC
- mem_stall  out  1  upstream must hold all ex_* inputs stable
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  32  word-aligned address ({ex_addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_byte_enable  out  4  active byte lanes
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  access complete, single-cycle pulse
- wb_valid  out  1  writeback record valid (one cycle)
- wb_rd  out  5  destination register
- wb_load_regfile  out  1  write rd
- wb_data  out  32  load result or ex_result
- wb_pc  out  32  instruction PC
- mem_fault  out  1  misaligned or illegal memory op (one cycle, with wb_valid)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset: state=IDLE; all outputs 0, including mem_stall, dmem_*, wb_* and mem_fault.
- Reset during ACCESS abandons the access. dmem_read/dmem_write are 0 in the cycle after rst is sampled. A late dmem_resp is ignored.
- FSM states: IDLE, ACCESS.
- mem_stall = (state==ACCESS) && !dmem_resp. This is combinational.
- Accept: ex_valid && !mem_stall on a rising edge.
- Non-memory accepted instruction (ex_load=ex_store=0):
  - wb_* registered next cycle with wb_data=ex_result and wb_valid=1.
  - Latency 1 cycle.
- Fault check at accept:
  - lh/lhu/sh with addr[0]=1 → fault.
  - lw/sw with addr[1:0]!=0 → fault.
  - Load funct3 011/110/111 → fault.
  - Store funct3 ≥011 → fault.
  - ex_load && ex_store together → fault.
- Faulting op issues no memory request. Next cycle: wb_valid=1, mem_fault=1, wb_load_regfile=0, wb_data=0.
- Legal memory op:
  - State→ACCESS.
  - dmem_read or dmem_write, address, wdata and byte_enable are registered. They are asserted from the cycle after accept and held constant until dmem_resp.
- Byte enables and store data:
  - sb: 4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - sh: 4'b0011<<addr[1:0], wdata={2{data[15:0]}}.
  - sw: 4'b1111, wdata=data.
  - Loads also drive the same enable pattern.
- On dmem_resp in ACCESS:
  - Next cycle wb_valid=1.
  - Load: wb_data = rdata>>(8*addr[1:0]), truncated to 8/16 bits, then sign-extended (lb/lh) or zero-extended (lbu/lhu); lw passes the full word.
  - Store: wb_load_regfile=0.
  - dmem_read/dmem_write deassert next cycle unless a new memory op is accepted in the resp cycle. In that case the new request is asserted back-to-back and state stays ACCESS.
- Simultaneous resp and accept: both are legal. The completing op writes back next cycle and the new op's wb follows later. Writeback order is program order.
- wb_load_regfile forced 0 when rd==0.
- dmem_resp in IDLE is ignored.
- wb_valid and mem_fault are high for exactly one cycle per record.
- Throughput: 1 instruction/cycle for non-memory ops. A memory op occupies ≥2 cycles (accept + ≥1 ACCESS cycle).

Test Plan:
- Reset during ACCESS: lw outstanding, rst=1 one cycle → dmem_read=0 next cycle, wb_valid=0. dmem_resp arriving afterwards produces no wb_valid.
- lb at addr 0x103, dmem_rdata=0x80FF_1234, resp after 3 cycles:
  - dmem_address=0x100, byte_enable=4'b1000.
  - mem_stall high 3 cycles.
  - wb_data=0xFFFF_FF80, wb_rd=ex_rd.
- lhu at 0x202 with rdata=0xBEEF_0000 → wb_data=0x0000_BEEF. sh at 0x202 with data=0x1234_5678 → wdata=0x5678_5678, byte_enable=4'b1100, wb_load_regfile=0.
- Faults:
  - lw at 0x301 → no dmem_read, next cycle mem_fault=1, wb_valid=1, wb_load_regfile=0.
  - Load funct3=111 → same response.
- Back-to-back sw 0x400 then lw 0x404, resp same cycle as second accept → dmem_write then dmem_read on consecutive cycles, wb records in order.
- Non-memory ops and rd=0:
  - Three ALU ops streamed → wb_valid three consecutive cycles, each 1-cycle latency, mem_stall=0 throughout.
  - lw to rd=0 → wb_load_regfile=0.
